axi_wr_slave_ctrl: RTL

// - AXI3-style write-slave endpoint sitting directly downstream of the write-ordering wrapper's master port.
// - Consumes AW/W bursts in AW order, drives a byte-enabled SRAM write port and returns one B per burst.
// - Holds up to AW_DEPTH addresses ahead of data and B_DEPTH responses so the wrapper's output FIFOs keep draining.

---
 rtl/axi_wr_slave_ctrl_pkg.sv | 55 +++++
 rtl/axi_wr_slave_ctrl_fifo.sv | 55 +++++
 rtl/axi_wr_slave_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/axi_wr_slave_ctrl_pkg.sv
// Shared widths, queue entry types and burst helpers for the AXI write-slave endpoint.
// Pure declarations: no state, no latency, no flow control.
package axi_wr_slave_ctrl_pkg;
  localparam int PID_WIDTH     = 4;
  localparam int PADDR_WIDTH   = 32;
  localparam int PLENGTH_WIDTH = 4;
  localparam int PSIZE_WIDTH   = 3;
  localparam int PDATA_WIDTH   = 4;
  localparam int PDATA_LOG2    = $clog2(PDATA_WIDTH);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef struct packed {
    logic [PID_WIDTH-1:0]     id;
    logic [PADDR_WIDTH-1:0]   addr;
    logic [PLENGTH_WIDTH-1:0] len;
    logic [PSIZE_WIDTH-1:0]   size;
    logic [1:0]               burst;
  } aw_entry_t;

  typedef struct packed {
    logic [PID_WIDTH-1:0] id;
    logic [1:0]           resp;
  } b_entry_t;

  typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_DRAIN} state_e;

  function automatic logic aw_illegal(input aw_entry_t aw);
    logic wrap_ok;
    wrap_ok = (aw.len == PLENGTH_WIDTH'(1)) || (aw.len == PLENGTH_WIDTH'(3)) ||
              (aw.len == PLENGTH_WIDTH'(7)) || (aw.len == PLENGTH_WIDTH'(15));
    return (aw.size > PSIZE_WIDTH'(PDATA_LOG2)) || (aw.burst == 2'b11) ||
           ((aw.burst == BURST_WRAP) && !wrap_ok);
  endfunction

  // WRAP keeps the upper bits of the (len+1)<<size aligned window and wraps the low bits.
  function automatic logic [PADDR_WIDTH-1:0] next_addr(input aw_entry_t aw,
                                                        input logic [PADDR_WIDTH-1:0] addr);
    logic [PADDR_WIDTH-1:0] step;
    logic [PADDR_WIDTH-1:0] mask;
    logic [PADDR_WIDTH-1:0] res;
    step = PADDR_WIDTH'(1) << aw.size;
    mask = ((PADDR_WIDTH'(aw.len) + PADDR_WIDTH'(1)) << aw.size) - PADDR_WIDTH'(1);
    case (aw.burst)
      BURST_INCR: res = addr + step;
      BURST_WRAP: res = (addr & ~mask) | ((addr + step) & mask);
      default:    res = addr;
    endcase
    return res;
  endfunction
endpackage

// File: rtl/axi_wr_slave_ctrl_fifo.sv
// Synchronous FIFO, output read straight from storage flops; push visible at output next cycle.
// Push is dropped when full unless a pop happens the same cycle; pop on empty is ignored.
module wr_slv_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == (PW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + PW'(1);
    cnt_d = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: rtl/axi_wr_slave_ctrl.sv
// AXI3 write slave: AW/W bursts in AW order to a registered SRAM port (write 1 cycle after beat), one B per burst.
// awready drops when aw_q is full; wready is low in IDLE and whenever b_q is full.
module axi_wr_slave_ctrl
  import axi_wr_slave_ctrl_pkg::*;
#(
  parameter int AW_DEPTH = 4,
  parameter int B_DEPTH  = 4,
  parameter int MEM_AW   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [PID_WIDTH-1:0]     awid,
  input  logic [PADDR_WIDTH-1:0]   awaddr,
  input  logic [PLENGTH_WIDTH-1:0] awlen,
  input  logic [PSIZE_WIDTH-1:0]   awsize,
  input  logic [1:0]               awburst,
  input  logic                     wvalid,
  output logic                     wready,
  input  logic [PID_WIDTH-1:0]     wid,
  input  logic [8*PDATA_WIDTH-1:0] wdata,
  input  logic [PDATA_WIDTH-1:0]   wstrb,
  input  logic                     wlast,
  output logic                     bvalid,
  input  logic                     bready,
  output logic [PID_WIDTH-1:0]     bid,
  output logic [1:0]               bresp,
  output logic                     mem_we,
  output logic [MEM_AW-1:0]        mem_addr,
  output logic [8*PDATA_WIDTH-1:0] mem_wdata,
  output logic [PDATA_WIDTH-1:0]   mem_be
);
  aw_entry_t aw_push_dat, aw_head, cur_q, cur_d;
  b_entry_t  b_push_dat, b_head;
  logic      aw_push, aw_pop, aw_full, aw_empty;
  logic      b_push, b_pop, b_full, b_empty;

  state_e                   state_q, state_d;
  logic [PLENGTH_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic [PADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                     err_q, err_d;
  logic                     live_q, live_d;
  logic                     mem_we_q, mem_we_d;
  logic [MEM_AW-1:0]        mem_addr_q, mem_addr_d;
  logic [8*PDATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [PDATA_WIDTH-1:0]   mem_be_q, mem_be_d;
  logic                     w_hs, beat_err;

  // live_q holds the ready outputs low for the first cycle out of reset.
  assign live_d      = 1'b1;
  assign awready     = live_q & ~aw_full;
  assign aw_push     = awvalid & awready;
  assign aw_push_dat = '{id: awid, addr: awaddr, len: awlen, size: awsize, burst: awburst};
  assign wready      = live_q & ~b_full & (state_q != ST_IDLE);
  assign w_hs        = wvalid & wready;
  assign bvalid      = ~b_empty;
  assign b_pop       = bvalid & bready;
  assign bid         = b_head.id;
  assign bresp       = b_head.resp;
  assign beat_err    = err_q | (wid != cur_q.id);

  wr_slv_fifo #(.WIDTH($bits(aw_entry_t)), .DEPTH(AW_DEPTH)) u_aw_q (
    .clk(clk), .rst_n(rst_n), .push(aw_push), .din(aw_push_dat), .pop(aw_pop),
    .dout(aw_head), .full(aw_full), .empty(aw_empty)
  );

  wr_slv_fifo #(.WIDTH($bits(b_entry_t)), .DEPTH(B_DEPTH)) u_b_q (
    .clk(clk), .rst_n(rst_n), .push(b_push), .din(b_push_dat), .pop(b_pop),
    .dout(b_head), .full(b_full), .empty(b_empty)
  );

  always_comb begin
    state_d         = state_q;
    cur_d           = cur_q;
    beat_cnt_d      = beat_cnt_q;
    addr_d          = addr_q;
    err_d           = err_q;
    aw_pop          = 1'b0;
    b_push          = 1'b0;
    b_push_dat.id   = cur_q.id;
    b_push_dat.resp = RESP_OKAY;
    mem_we_d        = 1'b0;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    mem_be_d        = mem_be_q;
    case (state_q)
      ST_IDLE: begin
        if (!aw_empty) begin
          aw_pop     = 1'b1;
          cur_d      = aw_head;
          addr_d     = aw_head.addr;
          beat_cnt_d = '0;
          err_d      = aw_illegal(aw_head);
          state_d    = ST_BURST;
        end
      end
      ST_BURST: begin
        if (w_hs) begin
          if (!beat_err) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = addr_q[PDATA_LOG2 +: MEM_AW];
            mem_wdata_d = wdata;
            mem_be_d    = wstrb;
          end
          // An early wlast closes the burst with SLVERR; a missing one drains to the real wlast.
          if (wlast) begin
            b_push          = 1'b1;
            b_push_dat.resp = (beat_err || (beat_cnt_q != cur_q.len)) ? RESP_SLVERR : RESP_OKAY;
            state_d         = ST_IDLE;
          end else if (beat_cnt_q == cur_q.len) begin
            err_d   = 1'b1;
            state_d = ST_DRAIN;
          end else begin
            beat_cnt_d = beat_cnt_q + PLENGTH_WIDTH'(1);
            addr_d     = next_addr(cur_q, addr_q);
            err_d      = beat_err;
          end
        end
      end
      ST_DRAIN: begin
        if (w_hs && wlast) begin
          b_push          = 1'b1;
          b_push_dat.resp = RESP_SLVERR;
          state_d         = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cur_q       <= '0;
      beat_cnt_q  <= '0;
      addr_q      <= '0;
      err_q       <= 1'b0;
      live_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      beat_cnt_q  <= beat_cnt_d;
      addr_q      <= addr_d;
      err_q       <= err_d;
      live_q      <= live_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
endmodule
